// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide bus: decoded controls and operands in, HI/LO and
// stall status out. The pipeline side is the master, the unit the slave.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            mthi;
    logic            mtlo;
    logic            rd_hilo;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;
    logic            busy;
    logic            done;
    logic            stall_req;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, rd_hilo,
        input  hi_out, lo_out, busy, done, stall_req
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, rd_hilo,
        output hi_out, lo_out, busy, done, stall_req
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO, with pipeline stall request.
// Optional macro MULDIV_EARLY_OUT_EN: multiply exits CALC once remaining multiplier bits are zero.
module ex_muldiv (
    input  logic            clk,
    input  logic            rst_n,
    ex_muldiv_if.slave      bus
);
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              div_q, div_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;     // multiplier (shifts right) or divisor
    logic [2*XLEN-1:0] mcand_q, mcand_d;     // multiplicand, shifts left each step
    logic [2*XLEN-1:0] acc_q, acc_d;         // product, or {remainder, quotient}
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              op_signed;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic              last_step;
    logic              div_by_zero;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Even op codes (MULT, DIV) are the signed variants.
    assign op_signed = ~bus.op[0];
    assign abs_a     = (op_signed && bus.src_a[XLEN-1]) ? -bus.src_a : bus.src_a;
    assign abs_b     = (op_signed && bus.src_b[XLEN-1]) ? -bus.src_b : bus.src_b;

    // Restoring divide step: bring in the next dividend bit, then trial-subtract.
    assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, mag_b_q};
    assign rem_sub   = rem_shift[XLEN-1:0] - mag_b_q;

`ifdef MULDIV_EARLY_OUT_EN
    assign last_step = (cnt_q == 6'd31) || (!div_q && (mag_b_q[XLEN-1:1] == '0));
`else
    assign last_step = (cnt_q == 6'd31);
`endif

    // A zero divisor keeps LO all-ones regardless of operand signs.
    assign div_by_zero = (mag_b_q == '0);
    assign prod_fix    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix     = ((sign_a_q ^ sign_b_q) && !div_by_zero) ? -acc_q[XLEN-1:0]
                                                                 : acc_q[XLEN-1:0];
    assign rem_fix     = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        div_d    = div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_b_d  = mag_b_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    div_d    = bus.op[1];
                    sign_a_d = op_signed & bus.src_a[XLEN-1];
                    sign_b_d = op_signed & bus.src_b[XLEN-1];
                    mag_b_d  = abs_b;
                    mcand_d  = {{XLEN{1'b0}}, abs_a};
                    acc_d    = bus.op[1] ? {{XLEN{1'b0}}, abs_a} : '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end else begin
                    if (bus.mthi) hi_d = bus.src_a;
                    if (bus.mtlo) lo_d = bus.src_a;
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (!div_q) begin
                    if (mag_b_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d = mcand_q << 1;
                    mag_b_d = mag_b_q >> 1;
                end else if (rem_ge) begin
                    acc_d = {rem_sub, acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                if (last_step) state_d = S_FIX;
            end

            S_FIX: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            div_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_b_q  <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q  <= state_d;
            div_q    <= div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_b_q  <= mag_b_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stall_req = busy_q & (bus.start | bus.rd_hilo | bus.mthi | bus.mtlo);
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO and busy length are queued at
// issue from an arithmetic model; a negedge monitor pops and compares on done.
module tb_ex_muldiv;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT_EN = 1'b1;
`else
    localparam bit EARLY_OUT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) bus ();
    ex_muldiv dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          busy_cnt = 0;
    logic [31:0] arch_hi = '0;
    logic [31:0] arch_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Cycles busy is high: 32 steps plus FIX, or early-out multiply steps plus FIX.
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] mag;
        int          steps;
        mag   = (op == OP_MULT && b[31]) ? -b : b;
        steps = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) steps = i + 1;
        return (EARLY_OUT_EN && !op[1]) ? steps + 1 : 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 40);
        return $urandom;
    endfunction

    task automatic push_expected(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_t        e;
        r     = ref_result(op, a, b);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.lat = ref_latency(op, b);
        sb_q.push_back(e);
        arch_hi = e.hi;
        arch_lo = e.lo;
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic wait_idle();
        for (int i = 0; i < 200 && bus.busy; i++) begin
            @(posedge clk);
            #1;
        end
        if (bus.busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        push_expected(op, a, b);
        bus.start = 1'b0;
    endtask

    task automatic move_to(input bit to_hi, input logic [31:0] val);
        wait_idle();
        bus.mthi  = to_hi;
        bus.mtlo  = !to_hi;
        bus.src_a = val;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (to_hi) begin
            arch_hi = val;
            check("mthi_value", {32'h0, bus.hi_out}, {32'h0, val});
        end else begin
            arch_lo = val;
            check("mtlo_value", {32'h0, bus.lo_out}, {32'h0, val});
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin : pop_blk
                exp_t e;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("hi_result", {32'h0, bus.hi_out}, {32'h0, e.hi});
                    check("lo_result", {32'h0, bus.lo_out}, {32'h0, e.lo});
                    check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] prev_hi, prev_lo;
        int          stall_cycles;

        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.rd_hilo = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", {32'h0, bus.hi_out}, 64'h0);
        check("reset_lo", {32'h0, bus.lo_out}, 64'h0);
        check("reset_busy", {63'h0, bus.busy}, 64'h0);
        check("reset_done", {63'h0, bus.done}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        issue(OP_DIVU,  32'd7,         32'd0);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd0);
        issue(OP_MULTU, 32'd3,         32'd5);
        issue(OP_MULTU, 32'd3,         32'd0);

        // Stalled MFHI plus a second start while busy; the start is re-presented until accepted.
        wait_idle();
        prev_hi = arch_hi;
        prev_lo = arch_lo;
        issue(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1234);
        bus.start   = 1'b1;
        bus.op      = OP_DIVU;
        bus.src_a   = 32'd1000;
        bus.src_b   = 32'd7;
        bus.rd_hilo = 1'b1;
        stall_cycles = 0;
        for (int i = 0; i < 100 && bus.busy; i++) begin
            check("stall_while_busy", {63'h0, bus.stall_req}, 64'h1);
            check("hilo_hold", {bus.hi_out, bus.lo_out}, {prev_hi, prev_lo});
            stall_cycles++;
            @(posedge clk);
            #1;
        end
        check("stall_cycles", 64'(stall_cycles), 64'(ref_latency(OP_MULTU, 32'h0000_1234)));
        check("no_stall_after_fix", {63'h0, bus.stall_req}, 64'h0);
        check("mfhi_sees_new", {bus.hi_out, bus.lo_out}, {arch_hi, arch_lo});
        @(posedge clk);
        #1;
        push_expected(OP_DIVU, 32'd1000, 32'd7);
        bus.start   = 1'b0;
        bus.rd_hilo = 1'b0;
        check("second_start_accepted", {63'h0, bus.busy}, 64'h1);

        move_to(1'b1, 32'h1234_5678);
        move_to(1'b0, 32'hCAFE_F00D);

        // start together with mthi: the move is discarded.
        wait_idle();
        prev_hi   = arch_hi;
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.op    = OP_MULTU;
        bus.src_a = 32'hAAAA_0000;
        bus.src_b = 32'd3;
        @(posedge clk);
        #1;
        push_expected(OP_MULTU, 32'hAAAA_0000, 32'd3);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check("start_beats_mthi", {32'h0, bus.hi_out}, {32'h0, prev_hi});

        // Asynchronous reset in the middle of a divide.
        issue(OP_DIVU, 32'hFFFF_FFF0, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'h0, bus.busy}, 64'h0);
        check("abort_hi", {32'h0, bus.hi_out}, 64'h0);
        check("abort_lo", {32'h0, bus.lo_out}, 64'h0);
        check("abort_done", {63'h0, bus.done}, 64'h0);
        sb_q.delete();
        arch_hi = '0;
        arch_lo = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(OP_MULTU, 32'd2, 32'd3);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) move_to($urandom_range(0, 1) == 1, $urandom);
            issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
        end

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drain", 64'(sb_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX pipeline register. It consumes the forwarded operands and the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO controls, owns the architectural HI/LO registers, and requests a pipeline stall while an operation is in flight. The stall request drives the freeze/flush controls of the upstream pipeline registers.

## Interface

- XLEN, 32, operand and HI/LO width; only 32 is supported.

- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  XLEN  rs operand (multiplicand / dividend), post-forwarding
- src_b  input  XLEN  rt operand (multiplier / divisor), post-forwarding
- mthi  input  1  write src_a into HI
- mtlo  input  1  write src_a into LO
- rd_hilo  input  1  EX instruction is MFHI/MFLO
- hi_out  output  XLEN  HI register
- lo_out  output  XLEN  LO register
- busy  output  1  operation in flight (registered)
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- stall_req  output  1  combinational: busy & (start | rd_hilo | mthi | mtlo)

## Operation

- States: IDLE, CALC, FIX.
- IDLE: start=1 latches op, operand magnitudes, sign bits; clears 6-bit iteration counter; -> CALC. mthi/mtlo with start=0 write HI/LO at that edge. start and mthi/mtlo together: start wins, move discarded.
- CALC: one radix-2 step per cycle on magnitudes. Multiply: shift-add into 64-bit accumulator. Divide: restoring, one quotient bit per step. After 32 steps -> FIX.
- FIX: apply signs (signed ops only). MULT: negate 64-bit product if sign_a^sign_b. DIV: negate quotient if sign_a^sign_b; negate remainder if sign_a. Write HI (product[63:32] / remainder), LO (product[31:0] / quotient); -> IDLE; done=1 next cycle.
- Divide by zero: no trap; LO=0xFFFFFFFF, HI=src_a (as latched), normal latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (falls out of magnitude algorithm; no special case).
- start, mthi, mtlo while busy: ignored by the unit; stall_req holds the instruction in EX until busy falls, when it is re-presented and accepted.
- rd_hilo while busy: stall_req=1; hi_out/lo_out hold previous values until FIX.
- Operands are not re-sampled after start; upstream flush does not abort an accepted operation.

## Timing

- Reset (async, any state): state IDLE, hi_out=0, lo_out=0, busy=0, done=0, counter=0. Reset mid-operation aborts; no partial HI/LO write.
- start accepted at edge E0; busy=1 after E0; CALC edges E1..E32; FIX edge E33 writes HI/LO, busy=0, done=1 for the cycle after E33.
- busy high 33 cycles per operation (default build).
- MFHI/MFLO in the cycle after E33: no stall, sees new value.
- mthi/mtlo in IDLE: HI/LO updated at that edge, visible next cycle.
- Back-to-back: a new start in the cycle after E33 is accepted (IDLE).

## Configuration

- MULDIV_EARLY_OUT_EN defined: multiply leaves CALC once remaining multiplier magnitude bits are all zero, minimum one CALC step; CALC steps = max(1, index of highest set bit of |src_b| + 1). Divide latency unchanged. done/busy semantics unchanged.
- Undefined: all operations take exactly 32 CALC steps.

## Test plan

- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 33 cycles, done pulse after E33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=7; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- rd_hilo=1 and a second start during busy -> stall_req=1 each cycle until E33, second start accepted in cycle after E33; MTHI 0x12345678 in IDLE -> hi_out=0x12345678 next cycle.
- rst_n low at cycle 10 of a DIVU -> immediately busy=0, hi_out=lo_out=0, state IDLE; subsequent MULTU 2x3 -> LO=6, HI=0.
- With MULDIV_EARLY_OUT_EN: MULTU 3 x 5 -> busy 4 cycles, LO=15; MULTU 3 x 0 -> busy 2 cycles, LO=0; without macro both take 33.
